pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Replaces the separate forwarding and load-use detection logic with a single unit.
- Keeps its own per-stage scoreboard of in-flight instructions.
- Drives PC/IF-ID enables, flush/bubble controls and EX operand forwarding selects.
- Adds a multi-cycle EX stall, a selectable branch-resolve stage and saturating stall/flush statistics counters.

Parameters:
REG_AW, 5, register address width
BR_STAGE, 2, stage in which a taken branch is resolved: 1 = EX, 2 = MEM
CNT_W, 16, width of statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
id_valid_i  in  1  ID holds a real instruction
id_rs_i  in  REG_AW  ID source register rs
id_rt_i  in  REG_AW  ID source register rt
id_rs_used_i  in  1  ID instruction reads rs
id_rt_used_i  in  1  ID instruction reads rt
id_wr_en_i  in  1  ID instruction writes a register
id_wr_addr_i  in  REG_AW  ID destination register (after RegDst)
id_is_load_i  in  1  ID instruction is a load
ex_busy_i  in  1  multi-cycle op in EX not finished this cycle
br_taken_i  in  1  branch in stage BR_STAGE resolved taken
pc_write_o  out  1  PC enable
if_id_write_o  out  1  IF/ID register enable
if_id_flush_o  out  1  load NOP into IF/ID
id_ex_bubble_o  out  1  zero control fields entering ID/EX
ex_flush_o  out  1  zero control fields entering EX/MEM
fwd_a_o  out  2  EX rs select: 00 = regfile, 01 = EX/MEM result, 10 = WB data
fwd_b_o  out  2  EX rt select, same encoding
stall_cnt_o  out  CNT_W  cycles with pc_write_o = 0
flush_cnt_o  out  CNT_W  taken-branch flush events

Behaviour:
- Scoreboard: entries EX, MEM, WB. Each entry holds {valid, wr_en, wr_addr, is_load, rs, rt, rs_used, rt_used}, loaded from the id_* inputs.
- Reset (rst_i = 1 at posedge): all entries invalid, counters 0.
- While rst_i = 1, outputs are forced to: pc_write_o = 1, if_id_write_o = 1, all flush/bubble outputs 0, fwd 00.
- Control outputs are combinational from the scoreboard and current inputs. Counters are registered with 1-cycle latency.
- Priority order: branch flush > ex_busy > load-use > normal.
- Branch flush, BR_STAGE = 1:
  - if_id_flush_o = 1, id_ex_bubble_o = 1, PC loads the target (pc_write_o = 1).
  - Normal shift, with a bubble entering EX.
- Branch flush, BR_STAGE = 2: as for BR_STAGE = 1, plus ex_flush_o = 1; the EX entry shifts into MEM as invalid.
  - ex_busy_i is ignored that cycle, because the EX op is younger and squashed.
- ex_busy (no flush):
  - pc_write_o = 0, if_id_write_o = 0; EX entry held.
  - ex_flush_o = 1, so MEM receives a bubble; WB <= MEM.
  - Load-use is not evaluated.
- Load-use (no flush, no busy):
  - Condition: EX.valid & EX.is_load & EX.wr_en & EX.wr_addr != 0 & ((id_rs_used_i & id_rs_i == EX.wr_addr) | (id_rt_used_i & id_rt_i == EX.wr_addr)), all gated by id_valid_i.
  - Response: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1; EX <= bubble, MEM <= EX, WB <= MEM.
  - Exactly one stall cycle per load-use pair.
- Normal: EX <= ID inputs (valid = id_valid_i), MEM <= EX, WB <= MEM.
- Forwarding (for the EX entry): fwd_a_o = 01 if MEM.valid & MEM.wr_en & MEM.wr_addr != 0 & MEM.wr_addr == EX.rs & EX.rs_used.
  - Else 10 if the same condition holds for WB.
  - Else 00. MEM has priority over WB. fwd_b_o is identical using rt.
  - fwd outputs are 00 when EX is invalid.
- Register file is write-through, so there is no WB-to-ID hazard.
- Register 0 never creates a hazard or a forward.
- Counters:
  - stall_cnt_o increments on every cycle with pc_write_o = 0.
  - flush_cnt_o increments on every cycle with br_taken_i = 1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall: the stall is abandoned. The next cycle after reset release is normal with an empty scoreboard.

Test Plan:
- `lw $2` then `add $3,$2,$4` (rs = 2) in ID -> one cycle with pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1. Next cycle fwd_a_o = 10; stall_cnt_o = 1.
- `add $5` then `sub $6,$5,$5` -> with sub in EX, fwd_a_o = 01 and fwd_b_o = 01. `add $5,..` with `nop` then `or $7,$0,$5` -> fwd_b_o = 10. Writes to $0 -> fwd 00.
- Same register in MEM and WB, e.g. `add $8` twice then a consumer of $8 -> fwd 01 (MEM wins).
- BR_STAGE = 2, br_taken_i pulse while ex_busy_i = 1 -> if_id_flush_o = id_ex_bubble_o = ex_flush_o = 1, pc_write_o = 1; flush_cnt_o = 1.
- ex_busy_i held 3 cycles with a load-use pair pending -> 3 cycles of freeze (ex_flush_o = 1), then one load-use stall; stall_cnt_o = 4.
- CNT_W = 4, 20 consecutive stall cycles -> stall_cnt_o = 15. rst_i asserted mid-stall -> next cycle outputs at reset values, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Unified hazard controller for a 5-stage pipeline (IF, ID, EX, MEM, WB).
//   It tracks the instructions in EX, MEM and WB in a private scoreboard and
//   from it produces the stall, flush and bubble controls and the EX operand
//   forwarding selects. Saturating counters record stall cycles and
//   taken-branch flushes.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   id_*_i                decoded fields of the instruction currently in ID
//   ex_busy_i             multi-cycle EX operation not finished this cycle
//   br_taken_i            branch in stage BR_STAGE resolved taken
//   pc_write_o            PC enable
//   if_id_write_o         IF/ID register enable
//   if_id_flush_o         load a NOP into IF/ID
//   id_ex_bubble_o        zero control fields entering ID/EX
//   ex_flush_o            zero control fields entering EX/MEM
//   fwd_a_o, fwd_b_o      EX rs/rt select: 00 regfile, 01 EX/MEM, 10 WB
//   stall_cnt_o           cycles with pc_write_o = 0 (saturating)
//   flush_cnt_o           taken-branch flush cycles (saturating)
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic              id_wr_en_i,
    input  logic [REG_AW-1:0] id_wr_addr_i,
    input  logic              id_is_load_i,
    input  logic              ex_busy_i,
    input  logic              br_taken_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_addr;
        logic              is_load;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } sb_entry_t;

    // MEM has priority over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input sb_entry_t mem, input sb_entry_t wb,
                                           input logic [REG_AW-1:0] src, input logic used);
        logic mem_hit;
        logic wb_hit;
        mem_hit = mem.valid & mem.wr_en & (mem.wr_addr != '0) & (mem.wr_addr == src) & used;
        wb_hit  = wb.valid & wb.wr_en & (wb.wr_addr != '0) & (wb.wr_addr == src) & used;
        if (mem_hit)     fwd_sel = 2'b01;
        else if (wb_hit) fwd_sel = 2'b10;
        else             fwd_sel = 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != '1)) sat_inc = cnt + CNT_W'(1);
        else                   sat_inc = cnt;
    endfunction

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    sb_entry_t w_id_entry;
    sb_entry_t w_ex_squashed;
    logic      w_flush;
    logic      w_busy;
    logic      w_load_use;

    always_comb begin
        w_id_entry         = '0;
        w_id_entry.valid   = id_valid_i;
        w_id_entry.wr_en   = id_wr_en_i;
        w_id_entry.wr_addr = id_wr_addr_i;
        w_id_entry.is_load = id_is_load_i;
        w_id_entry.rs      = id_rs_i;
        w_id_entry.rt      = id_rt_i;
        w_id_entry.rs_used = id_rs_used_i;
        w_id_entry.rt_used = id_rt_used_i;

        w_ex_squashed       = r_ex;
        w_ex_squashed.valid = 1'b0;
    end

    // A taken branch outranks a busy EX: the EX op is on the wrong path (or,
    // when resolving in EX, the branch itself) and is not held.
    assign w_flush    = br_taken_i;
    assign w_busy     = ex_busy_i & ~w_flush;
    assign w_load_use = id_valid_i & r_ex.valid & r_ex.is_load & r_ex.wr_en &
                        (r_ex.wr_addr != '0) &
                        ((id_rs_used_i & (id_rs_i == r_ex.wr_addr)) |
                         (id_rt_used_i & (id_rt_i == r_ex.wr_addr)));

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_flush_o     = 1'b0;
        fwd_a_o        = 2'b00;
        fwd_b_o        = 2'b00;
        if (!rst_i) begin
            if (w_flush) begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                ex_flush_o     = (BR_STAGE == 2);
            end else if (w_busy) begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                ex_flush_o    = 1'b1;
            end else if (w_load_use) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
            if (r_ex.valid) begin
                fwd_a_o = fwd_sel(r_mem, r_wb, r_ex.rs, r_ex.rs_used);
                fwd_b_o = fwd_sel(r_mem, r_wb, r_ex.rt, r_ex.rt_used);
            end
        end
    end

    // Scoreboard shift and statistics counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex.valid  <= 1'b0;
            r_mem.valid <= 1'b0;
            r_wb.valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wb <= r_mem;
            if (w_flush) begin
                r_ex  <= '0;
                r_mem <= (BR_STAGE == 2) ? w_ex_squashed : r_ex;
            end else if (w_busy) begin
                r_ex  <= r_ex;
                r_mem <= '0;
            end else if (w_load_use) begin
                r_ex  <= '0;
                r_mem <= r_ex;
            end else begin
                r_ex  <= w_id_entry;
                r_mem <= r_ex;
            end
            r_stall_cnt <= sat_inc(r_stall_cnt, ~pc_write_o);
            r_flush_cnt <= sat_inc(r_flush_cnt, br_taken_i);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
//   u_dut2 resolves branches in MEM with 16-bit counters, u_dut1 resolves in
//   EX with 4-bit counters. Control outputs are packed as
//   {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_flush}.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wr_en;
    logic [4:0] id_wr_addr;
    logic       id_is_load;
    logic       ex_busy;
    logic       br_taken;

    logic        pc_a, ifid_a, iff_a, bub_a, exf_a;
    logic [1:0]  fwd_a_a, fwd_b_a;
    logic [15:0] stall_a, flush_a;
    logic        pc_b, ifid_b, iff_b, bub_b, exf_b;
    logic [1:0]  fwd_a_b, fwd_b_b;
    logic [3:0]  stall_b, flush_b;

    logic [4:0] ctrl_a;
    logic [4:0] ctrl_b;
    assign ctrl_a = {pc_a, ifid_a, iff_a, bub_a, exf_a};
    assign ctrl_b = {pc_b, ifid_b, iff_b, bub_b, exf_b};

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(2), .CNT_W(16)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_wr_en_i(id_wr_en), .id_wr_addr_i(id_wr_addr), .id_is_load_i(id_is_load),
        .ex_busy_i(ex_busy), .br_taken_i(br_taken),
        .pc_write_o(pc_a), .if_id_write_o(ifid_a), .if_id_flush_o(iff_a),
        .id_ex_bubble_o(bub_a), .ex_flush_o(exf_a),
        .fwd_a_o(fwd_a_a), .fwd_b_o(fwd_b_a),
        .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(1), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_wr_en_i(id_wr_en), .id_wr_addr_i(id_wr_addr), .id_is_load_i(id_is_load),
        .ex_busy_i(ex_busy), .br_taken_i(br_taken),
        .pc_write_o(pc_b), .if_id_write_o(ifid_b), .if_id_flush_o(iff_b),
        .id_ex_bubble_o(bub_b), .ex_flush_o(exf_b),
        .fwd_a_o(fwd_a_b), .fwd_b_o(fwd_b_b),
        .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic ru,
                          input logic tu, input logic we, input int wa, input logic ld);
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_rs_used = ru;
        id_rt_used = tu;
        id_wr_en   = we;
        id_wr_addr = 5'(wa);
        id_is_load = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        // Reset with busy and branch asserted: outputs must stay at reset values
        rst = 1'b1; ex_busy = 1'b1; br_taken = 1'b1;
        nop();
        tick(); tick(); settle();
        check("rst_ctrl_a", 32'(ctrl_a), 'b11000);
        check("rst_ctrl_b", 32'(ctrl_b), 'b11000);
        check("rst_fwd_a", 32'({fwd_a_a, fwd_b_a}), 0);
        check("rst_stall_a", 32'(stall_a), 0);
        check("rst_flush_a", 32'(flush_a), 0);
        rst = 1'b0; ex_busy = 1'b0; br_taken = 1'b0;
        tick();

        // lw $2 ; add $3,$2,$4
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        settle();
        check("lw_ctrl", 32'(ctrl_a), 'b11000);
        tick();
        set_id(1'b1, 2, 4, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        settle();
        check("lu_ctrl_a", 32'(ctrl_a), 'b00010);
        check("lu_ctrl_b", 32'(ctrl_b), 'b00010);
        tick();
        check("lu_stall_a", 32'(stall_a), 1);
        settle();
        check("lu_once", 32'(ctrl_a), 'b11000);
        tick();
        nop();
        settle();
        check("lu_fwd_wb", 32'({fwd_a_a, fwd_b_a}), 'b1000);
        tick();

        // add $5 ; sub $6,$5,$5
        set_id(1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 5, 1'b0);
        tick();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        settle();
        check("sub_noload", 32'(ctrl_a), 'b11000);
        tick();
        nop();
        settle();
        check("fwd_mem", 32'({fwd_a_a, fwd_b_a}), 'b0101);
        tick();

        // add $5 ; nop ; or $7,$0,$5
        set_id(1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 5, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 0, 5, 1'b1, 1'b1, 1'b1, 7, 1'b0);
        tick();
        nop();
        settle();
        check("fwd_wb_b", 32'({fwd_a_a, fwd_b_a}), 'b0010);
        tick();

        // lw $0 ; consumer of $0: no stall, no forward
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        tick();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 9, 1'b0);
        settle();
        check("r0_nolu", 32'(ctrl_a), 'b11000);
        tick();
        nop();
        settle();
        check("r0_fwd", 32'({fwd_a_a, fwd_b_a}), 0);
        tick();

        // add $8 ; add $8 ; consumer of $8: MEM wins over WB
        set_id(1'b1, 1, 1, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        tick();
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        tick();
        set_id(1'b1, 8, 9, 1'b1, 1'b1, 1'b1, 10, 1'b0);
        tick();
        nop();
        settle();
        check("fwd_prio", 32'({fwd_a_a, fwd_b_a}), 'b0100);
        tick();

        // Invalid ID / invalid EX entries with matching fields must be ignored
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 10, 1'b1);
        tick();
        set_id(1'b0, 10, 10, 1'b1, 1'b1, 1'b1, 11, 1'b0);
        settle();
        check("lu_gate", 32'(ctrl_a), 'b11000);
        tick();
        nop();
        settle();
        check("fwd_inv", 32'({fwd_a_a, fwd_b_a}), 0);
        tick();

        // Reset clears counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_stall_a", 32'(stall_a), 0);
        check("rst2_stall_b", 32'(stall_b), 0);

        // Busy for 3 cycles with a load-use pair pending, then one stall
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        tick();
        set_id(1'b1, 2, 4, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("busy_ctrl", 32'(ctrl_a), 'b00001);
            tick();
        end
        ex_busy = 1'b0;
        settle();
        check("busy_lu", 32'(ctrl_a), 'b00010);
        tick();
        check("busy_stall_a", 32'(stall_a), 4);
        check("busy_stall_b", 32'(stall_b), 4);
        settle();
        check("busy_after", 32'(ctrl_a), 'b11000);
        tick();

        // Taken branch while busy; add $11 in EX is squashed only when BR_STAGE = 2
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 11, 1'b0);
        tick();
        set_id(1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 12, 1'b0);
        br_taken = 1'b1; ex_busy = 1'b1;
        settle();
        check("br_ctrl_a", 32'(ctrl_a), 'b11111);
        check("br_ctrl_b", 32'(ctrl_b), 'b11110);
        tick();
        br_taken = 1'b0; ex_busy = 1'b0;
        check("br_flush_a", 32'(flush_a), 1);
        check("br_flush_b", 32'(flush_b), 1);
        check("br_stall_a", 32'(stall_a), 4);
        set_id(1'b1, 11, 0, 1'b1, 1'b0, 1'b1, 13, 1'b0);
        tick();
        nop();
        settle();
        check("br_sq_a", 32'(fwd_a_a), 0);
        check("br_sq_b", 32'(fwd_a_b), 'b10);
        tick();

        // 20 busy cycles: 16-bit counter counts on, 4-bit counter saturates
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 12, 1'b1);
        tick();
        set_id(1'b1, 12, 0, 1'b1, 1'b0, 1'b1, 14, 1'b0);
        ex_busy = 1'b1;
        repeat (20) tick();
        check("sat_a", 32'(stall_a), 24);
        check("sat_b", 32'(stall_b), 15);

        // Reset in the middle of the freeze
        rst = 1'b1;
        settle();
        check("rst_mid_ctrl_a", 32'(ctrl_a), 'b11000);
        check("rst_mid_ctrl_b", 32'(ctrl_b), 'b11000);
        tick();
        check("rst_mid_stall_a", 32'(stall_a), 0);
        check("rst_mid_stall_b", 32'(stall_b), 0);
        check("rst_mid_flush_a", 32'(flush_a), 0);
        rst = 1'b0; ex_busy = 1'b0;
        settle();
        check("post_rst_a", 32'(ctrl_a), 'b11000);
        check("post_rst_b", 32'(ctrl_b), 'b11000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
